// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   op_e    : operation encodings as presented on the op port
//   state_e : sequencing states of the unit (IDLE -> RUN -> FIX -> IDLE)
//   helpers : op classification used by the decode logic
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {acc,q} register pair, purely combinational.
//   is_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i    : upper half (partial product / partial remainder)
//   q_i      : lower half (multiplier bits / dividend bits -> quotient bits)
//   b_i      : multiplicand magnitude or divisor magnitude
//   acc_o    : next upper half
//   q_o      : next lower half
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] tmp;
    logic [WIDTH:0] diff;

    always_comb begin
        sum   = {1'b0, acc_i} + (q_i[0] ? {1'b0, b_i} : '0);
        tmp   = {acc_i, q_i[WIDTH-1]};
        diff  = tmp - {1'b0, b_i};
        acc_o = acc_i;
        q_o   = q_i;
        if (is_div_i) begin
            // acc < b always holds, so tmp < 2b: the top bit of diff is a clean borrow.
            if (!diff[WIDTH]) begin
                acc_o = diff[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = tmp[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Add, then shift the (WIDTH+1)-bit sum right across the register pair.
            acc_o = sum[WIDTH:1];
            q_o   = {sum[0], q_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//   clk         : rising-edge clock
//   rst         : asynchronous active-low reset
//   start/op    : request and operation, sampled only in IDLE
//   src_a/src_b : multiplicand/dividend, multiplier/divisor
//   flush       : abort an in-flight op (RUN or FIX)
//   hi_we/lo_we : mthi/mtlo strobes, honoured only when not busy
//   wr_data     : mthi/mtlo data
//   busy        : op in flight
//   done        : one-cycle pulse after HI/LO are written by a completed op
//   div_by_zero : last completed op was a divide with a zero divisor
//   hi/lo       : HI and LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    function automatic logic [WIDTH-1:0] fix_word(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? ((~x) + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_prod(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? ((~x) + (2*WIDTH)'(1)) : x;
    endfunction

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    acc_q, q_q, b_q;
    logic [WIDTH-1:0]    hi_q, lo_q;
    logic                is_div_q, qneg_q, rneg_q, dzop_q, dz_q, done_q;
    logic [WIDTH-1:0]    acc_nxt, q_nxt;

    op_e                    op_in;
    logic                   in_div, in_signed, a_neg, b_neg, b_zero, dz_start, accept;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]       a_mag, b_mag;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix, rem_fix;

    // Request decode: operand magnitudes and result signs for the unsigned core.
    assign op_in     = op_e'(op);
    assign in_div    = op_is_div(op_in);
    assign in_signed = op_is_signed(op_in);
    assign a_s       = $signed(src_a);
    assign b_s       = $signed(src_b);
    assign a_neg     = in_signed && (a_s < 0);
    assign b_neg     = in_signed && (b_s < 0);
    assign a_mag     = fix_word(src_a, a_neg);
    assign b_mag     = fix_word(src_b, b_neg);
    assign b_zero    = (src_b == '0);
    assign dz_start  = in_div && b_zero;
    assign accept    = (state_q == S_IDLE) && start && !flush;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .q_i      (q_q),
        .b_i      (b_q),
        .acc_o    (acc_nxt),
        .q_o      (q_nxt)
    );

    // Sign fix-up of the unsigned core result; MIN/-1 falls out as lo=MIN, hi=0.
    assign prod_fix = fix_prod({acc_q, q_q}, qneg_q);
    assign quo_fix  = fix_word(q_q, qneg_q);
    assign rem_fix  = fix_word(acc_q, rneg_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = dz_start ? S_FIX : S_RUN;
            S_RUN: begin
                if (flush)                    state_d = S_IDLE;
                else if (cnt_q == CNT_W'(1))  state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dzop_q   <= 1'b0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (hi_we) hi_q <= wr_data;
                    if (lo_we) lo_q <= wr_data;
                    if (accept) begin
                        cnt_q    <= CNT_W'(WIDTH);
                        is_div_q <= in_div;
                        dzop_q   <= dz_start;
                        if (dz_start) begin
                            // Result is preloaded; FIX passes it through unsigned.
                            acc_q  <= src_a;
                            q_q    <= '1;
                            b_q    <= '0;
                            qneg_q <= 1'b0;
                            rneg_q <= 1'b0;
                        end else if (in_div) begin
                            acc_q  <= '0;
                            q_q    <= a_mag;
                            b_q    <= b_mag;
                            qneg_q <= a_neg ^ b_neg;
                            rneg_q <= a_neg;
                        end else begin
                            acc_q  <= '0;
                            q_q    <= b_mag;
                            b_q    <= a_mag;
                            qneg_q <= a_neg ^ b_neg;
                            rneg_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_nxt;
                    q_q   <= q_nxt;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                S_FIX: begin
                    if (!flush) begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            {hi_q, lo_q} <= prod_fix;
                        end
                        dz_q   <= dzop_q;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         flush = 1'b0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wr_data = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .flush       (flush),
        .hi_we       (hi_we),
        .lo_we       (lo_we),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // Reference arithmetic straight from the instruction definitions, in 64-bit.
    function automatic void model_exec(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                       output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rdz);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        rdz = 1'b0;
        rh  = '0;
        rl  = '0;
        case (o)
            2'b00: begin p = sa * sb; rh = p[63:32]; rl = p[31:0]; end
            2'b01: begin p = ua * ub; rh = p[63:32]; rl = p[31:0]; end
            default: begin
                if (b == '0) begin
                    rl = '1; rh = a; rdz = 1'b1;
                end else if (o == 2'b10) begin
                    sq = sa / sb; sr = sa % sb;
                    p = sq; rl = p[31:0];
                    p = sr; rh = p[31:0];
                end else begin
                    p = ua / ub; rl = p[31:0];
                    p = ua % ub; rh = p[31:0];
                end
            end
        endcase
    endfunction

    // Transaction-level model: an accepted op completes a fixed number of edges later.
    logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0, p_dz = 1'b0;
    logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    int           m_left = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy = 1'b0;
                end else begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_busy = 1'b0; m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1'b1;
                    end
                end
            end else begin
                if (hi_we) m_hi = wr_data;
                if (lo_we) m_lo = wr_data;
                if (start && !flush) begin
                    model_exec(op, src_a, src_b, p_hi, p_lo, p_dz);
                    m_left = (op[1] && src_b == '0) ? 1 : W + 1;
                    m_busy = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        total++;
        if (busy !== m_busy || done !== m_done || div_by_zero !== m_dz || hi !== m_hi || lo !== m_lo) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t actual/required busy=%b/%b done=%b/%b dz=%b/%b hi=%h/%h lo=%h/%h",
                     $time, busy, m_busy, done, m_done, div_by_zero, m_dz, hi, m_hi, lo, m_lo);
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; start is seen by the next rising edge.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc = 0;
        bcnt = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input int elat);
        int cyc, bcnt;
        issue(o, a, b);
        wait_done(cyc, bcnt);
        chk({name, "_lat"}, cyc, elat);
        chk({name, "_hi"}, hi, ehi);
        chk({name, "_lo"}, lo, elo);
    endtask

    initial begin
        int cyc, bcnt;

        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // MULT -3*7 with exact busy window
        issue(2'b00, 32'hFFFF_FFFD, 32'd7);
        wait_done(cyc, bcnt);
        chk("mult_busy_cycles", bcnt, 32'd33);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFEB);

        run_op("divu_1024_3", 2'b11, 32'd1024, 32'd3, 32'd1, 32'd341, 33);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
        run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);

        run_op("div_zero", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1);
        chk("dz_set", {31'b0, div_by_zero}, 32'd1);
        run_op("mult_2_2", 2'b00, 32'd2, 32'd2, 32'd0, 32'd4, 33);
        chk("dz_clear", {31'b0, div_by_zero}, 32'd0);

        // Flush in the 10th RUN cycle while a second start is held high
        issue(2'b01, 32'd6, 32'd7);
        start = 1'b1; op = 2'b11; src_a = 32'd100; src_b = 32'd3;
        repeat (9) @(negedge clk);
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'd0);
        chk("flush_done", {31'b0, done}, 32'd0);
        chk("flush_hi", hi, 32'd0);
        chk("flush_lo", lo, 32'd4);
        repeat (3) @(negedge clk);
        chk("no_queue_busy", {31'b0, busy}, 32'd0);

        // flush beats start in IDLE
        start = 1'b1; flush = 1'b1; op = 2'b00; src_a = 32'd1; src_b = 32'd1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {31'b0, busy}, 32'd0);

        lo_we = 1'b1; wr_data = 32'h1234;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo", lo, 32'h1234);

        run_op("divu_zero", 2'b11, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1);

        // mthi ignored while busy, then async reset mid-RUN
        issue(2'b00, 32'd3, 32'd5);
        repeat (3) @(negedge clk);
        hi_we = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0;
        chk("mthi_busy_hi", hi, 32'd9);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_dz", {31'b0, div_by_zero}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_op("div_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 33);
        run_op("div_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 33);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
